// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } fetch_state_e;

    localparam int          INST_BYTES   = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0010;

endpackage

// File: rtl/fetch_boot_timer.sv
// Post-reset boot delay: loads BOOT_DELAY on reset and counts down while
// enabled; done_o is the terminal-count compare.
module fetch_boot_timer
#(
    parameter int BOOT_DELAY = 1
)
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic done_o
);

    localparam int             CW   = (BOOT_DELAY < 2) ? 1 : $clog2(BOOT_DELAY + 1);
    localparam logic [CW-1:0]  LOAD = CW'(BOOT_DELAY);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Decrement while enabled until the terminal count is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, reloaded by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake,
// presents fetched words to decode and applies branch/jump redirects.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirects go to
// TRAP_VEC and pulse misalign_err_o; otherwise the low PC bits are cleared).
//
// state | meaning
// BOOT  | post-reset delay, no requests, redirects ignored
// REQ   | imem_req_o high, waiting for imem_ack_i
// VALID | instruction presented to decode, held while stalled
module fetch_seq_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter int          BOOT_DELAY = 1,
    parameter logic [31:0] TRAP_VEC   = DEF_TRAP_VEC
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    output logic [31:0] fetch_cnt_o,
    output logic        misalign_err_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic         inst_valid_q, inst_valid_d;
    logic [31:0]  fetch_cnt_q, fetch_cnt_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic         pend_valid_q, pend_valid_d;
    logic         boot_done;
    logic [31:0]  redir_tgt;

    fetch_boot_timer #(
        .BOOT_DELAY (BOOT_DELAY)
    ) u_boot_timer (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == BOOT),
        .done_o (boot_done)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    logic redir_misaligned;
    logic misalign_q;

    assign redir_misaligned = (redirect_pc_i[1:0] != 2'b00);
    assign redir_tgt        = redir_misaligned ? TRAP_VEC : redirect_pc_i;

    // One-cycle error pulse for any misaligned redirect the FSM actually samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_valid_i && redir_misaligned && (state_q != BOOT);
        end
    end

    assign misalign_err_o = misalign_q;
`else
    logic unused_cfg;

    assign redir_tgt      = {redirect_pc_i[31:2], 2'b00};
    assign misalign_err_o = 1'b0;
    assign unused_cfg     = ^{redirect_pc_i[1:0], TRAP_VEC};
`endif

    // Next-state logic. An ack that arrives with a newer redirect outstanding
    // (same cycle or pending) carries a stale word, so it is dropped.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        fetch_cnt_d  = fetch_cnt_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        case (state_q)
            BOOT: begin
                if (boot_done) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ack_i) begin
                    if (redirect_valid_i) begin
                        pc_d         = redir_tgt;
                        pend_valid_d = 1'b0;
                    end else if (pend_valid_q) begin
                        pc_d         = pend_pc_q;
                        pend_valid_d = 1'b0;
                    end else begin
                        inst_d       = imem_rdata_i;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + 32'(INST_BYTES);
                        state_d      = VALID;
                    end
                end else if (redirect_valid_i) begin
                    pend_pc_d    = redir_tgt;
                    pend_valid_d = 1'b1;
                end
            end
            VALID: begin
                if (redirect_valid_i) begin
                    inst_valid_d = 1'b0;
                    pc_d         = redir_tgt;
                    state_d      = REQ;
                end else if (!stall_i) begin
                    fetch_cnt_d  = fetch_cnt_q + 32'd1;
                    inst_valid_d = 1'b0;
                    state_d      = REQ;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
            inst_valid_q <= 1'b0;
            fetch_cnt_q  <= 32'd0;
            pend_pc_q    <= 32'd0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign imem_req_o   = (state_q == REQ);
    assign imem_addr_o  = pc_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = inst_valid_q;
    assign fetch_cnt_o  = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Bench for fetch_seq_ctrl: directed scenarios followed by random stall,
// redirect and ack traffic, checked against a behavioural model. Delivered
// instructions are scoreboarded by a separate monitor.
module tb_fetch_seq_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          BD     = 1;
    localparam logic [31:0] TV     = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'd0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic [31:0] fetch_cnt_o;
    logic        misalign_err_o;

    always #5 clk = ~clk;

    fetch_seq_ctrl #(
        .RESET_PC   (RST_PC),
        .BOOT_DELAY (BD),
        .TRAP_VEC   (TV)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_ack_i       (imem_ack_i),
        .imem_rdata_i     (imem_rdata_i),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .inst_valid_o     (inst_valid_o),
        .fetch_cnt_o      (fetch_cnt_o),
        .misalign_err_o   (misalign_err_o)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: what the fetcher is doing right now, in plain terms.
    int          boot_left;
    bit          m_boot, m_wait, m_hold, m_pend_v, m_mis;
    logic [31:0] m_pc, m_pend_pc, m_cnt, m_inst, m_inst_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } deliv_t;
    deliv_t exp_q[$];
    deliv_t mon_e;
    bit     prev_v;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] target(input logic [31:0] r);
`ifdef FETCH_MISALIGN_TRAP_EN
        return (r[1:0] != 2'b00) ? TV : r;
`else
        return r & 32'hFFFF_FFFC;
`endif
    endfunction

    task automatic model_reset();
        boot_left = BD;
        m_boot    = 1;
        m_wait    = 0;
        m_hold    = 0;
        m_pend_v  = 0;
        m_mis     = 0;
        m_pc      = RST_PC;
        m_pend_pc = 0;
        m_cnt     = 0;
        m_inst    = 0;
        m_inst_pc = 0;
    endtask

    task automatic check_now();
        chk("imem_req", imem_req_o, m_wait);
        chk("imem_addr", imem_addr_o, m_pc);
        chk("inst_valid", inst_valid_o, m_hold);
        chk("inst", inst_o, m_inst);
        chk("inst_pc", inst_pc_o, m_inst_pc);
        chk("fetch_cnt", fetch_cnt_o, m_cnt);
        chk("misalign_err", misalign_err_o, m_mis);
    endtask

    // Called on a falling edge: check, drive inputs, advance model one clock.
    task automatic cyc(input bit st, input bit rv, input logic [31:0] rpc,
                       input bit ack, input logic [31:0] rd);
        logic [31:0] t;
        check_now();
        stall_i          = st;
        redirect_valid_i = rv;
        redirect_pc_i    = rpc;
        imem_ack_i       = ack;
        imem_rdata_i     = rd;
        t     = target(rpc);
        m_mis = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (rv && !m_boot && (rpc[1:0] != 2'b00)) m_mis = 1;
`endif
        if (m_boot) begin
            if (boot_left == 0) begin
                m_boot = 0;
                m_wait = 1;
            end else begin
                boot_left--;
            end
        end else if (m_wait) begin
            if (ack) begin
                if (rv) begin
                    m_pc     = t;
                    m_pend_v = 0;
                end else if (m_pend_v) begin
                    m_pc     = m_pend_pc;
                    m_pend_v = 0;
                end else begin
                    exp_q.push_back('{pc: m_pc, data: rd});
                    m_inst    = rd;
                    m_inst_pc = m_pc;
                    m_pc      = m_pc + 4;
                    m_wait    = 0;
                    m_hold    = 1;
                end
            end else if (rv) begin
                m_pend_pc = t;
                m_pend_v  = 1;
            end
        end else if (m_hold) begin
            if (rv) begin
                m_hold = 0;
                m_wait = 1;
                m_pc   = t;
            end else if (!st) begin
                m_cnt  = m_cnt + 1;
                m_hold = 0;
                m_wait = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 32'd0, 0, 32'd0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        imem_ack_i = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_req", imem_req_o, 0);
        chk("rst_addr", imem_addr_o, RST_PC);
        chk("rst_inst", inst_o, 0);
        chk("rst_inst_pc", inst_pc_o, 0);
        chk("rst_inst_valid", inst_valid_o, 0);
        chk("rst_fetch_cnt", fetch_cnt_o, 0);
        chk("rst_misalign", misalign_err_o, 0);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    // Scoreboard monitor: each new instruction presentation pops one expectation.
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 0;
        end else begin
            if (inst_valid_o && !prev_v) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: got pc %h inst %h expected none", inst_pc_o, inst_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_inst", inst_o, mon_e.data);
                    chk("sb_pc", inst_pc_o, mon_e.pc);
                end
            end
            prev_v = inst_valid_o;
        end
    end

    initial begin
        bit          st, rv, ack;
        logic [31:0] rpc;
        int          sel;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Boot delay of one cycle: first request in cycle 2 after release.
        idle();
        idle();
        chk("first_req", imem_req_o, 1);
        chk("first_addr", imem_addr_o, 32'h0);
        idle();
        cyc(0, 0, 32'd0, 1, 32'h0050_0093);
        chk("first_valid", inst_valid_o, 1);
        chk("first_inst_pc", inst_pc_o, 32'h0);

        // Stall held three cycles.
        repeat (3) cyc(1, 0, 32'd0, 0, 32'd0);
        chk("stall_inst", inst_o, 32'h0050_0093);
        chk("stall_cnt", fetch_cnt_o, 0);
        idle();
        chk("post_stall_cnt", fetch_cnt_o, 1);
        chk("post_stall_addr", imem_addr_o, 32'h4);

        // Redirect beats stall in VALID.
        cyc(0, 0, 32'd0, 1, 32'h1111_2222);
        cyc(1, 1, 32'h40, 0, 32'd0);
        chk("redir_stall_valid", inst_valid_o, 0);
        chk("redir_stall_addr", imem_addr_o, 32'h40);

        // Redirect while waiting for a slow ack: old address held, data dropped.
        cyc(0, 1, 32'h80, 0, 32'd0);
        idle();
        idle();
        chk("pend_hold_addr", imem_addr_o, 32'h40);
        cyc(0, 0, 32'd0, 1, 32'hDEAD_BEEF);
        chk("pend_no_valid", inst_valid_o, 0);
        chk("pend_new_addr", imem_addr_o, 32'h80);

        // PC wrap at the top of the address space.
        cyc(0, 0, 32'd0, 1, 32'hA5A5_0001);
        cyc(0, 1, 32'hFFFF_FFFC, 0, 32'd0);
        cyc(0, 0, 32'd0, 1, 32'hA5A5_0002);
        chk("wrap_inst_pc", inst_pc_o, 32'hFFFF_FFFC);
        idle();
        chk("wrap_addr", imem_addr_o, 32'h0);

        // Misaligned redirect.
        cyc(0, 0, 32'd0, 1, 32'hA5A5_0003);
        cyc(0, 1, 32'h102, 0, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_addr", imem_addr_o, 32'h10);
        chk("mis_pulse", misalign_err_o, 1);
`else
        chk("mis_addr", imem_addr_o, 32'h100);
        chk("mis_pulse", misalign_err_o, 0);
`endif
        idle();
        chk("mis_pulse_end", misalign_err_o, 0);

        // Random traffic with one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            st  = ($urandom_range(0, 9) < 3);
            rv  = ($urandom_range(0, 9) == 0);
            ack = ($urandom_range(0, 9) < 4);
            sel = $urandom_range(0, 7);
            if (sel == 0)      rpc = 32'hFFFF_FFFC;
            else if (sel == 1) rpc = $urandom();
            else               rpc = $urandom() & 32'h0000_FFFC;
            cyc(st, rv, rpc, ack, $urandom());
        end
        repeat (3) idle();
        chk("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
- Instruction-fetch sequencer that owns the program counter and drives a req/ack handshake to instruction memory.
- Delivers fetched instructions with their PC to decode; handles decode stalls and branch/jump redirects.
- Provides a programmable post-reset boot delay before the first fetch.
- Sits between the next-PC logic in execute and the IROM/bus port.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BOOT_DELAY, 1, cycles in BOOT after reset release before the first request (0 = fetch on first cycle).
- TRAP_VEC, 32'h0000_0010, target used for a misaligned redirect (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall  in  1  decode cannot accept; hold current instruction
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  32  redirect target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_ack  in  1  data valid on imem_rdata this cycle
- imem_rdata  in  32  fetched word
- inst  out  32  instruction to decode
- inst_pc  out  32  PC of inst
- inst_valid  out  1  inst/inst_pc valid
- fetch_cnt  out  32  retired-fetch counter
- misalign_err  out  1  one-cycle pulse on misaligned redirect (tied 0 without feature)

Behaviour:
- Reset is asynchronous, active-high (rst); clock is clk. All state is updated on the rising edge of clk.
- Reset values:
  - pc = RESET_PC; state = BOOT; boot count = 0.
  - imem_req = 0; imem_addr = RESET_PC.
  - inst = 0; inst_pc = 0; inst_valid = 0; fetch_cnt = 0; misalign_err = 0.
  - pend_valid = 0; pend_pc = 0.
- Reset asserted mid-operation drops all outputs to their reset values immediately. Any in-flight ack after reset release is ignored.
- imem_addr always equals pc. A registered imem_req (and its address) must remain stable until imem_ack.
- State BOOT:
  - Count cycles; after BOOT_DELAY cycles go to REQ. With BOOT_DELAY = 0, go to REQ on the first edge after reset release.
  - redirect_valid is ignored in BOOT.
- State REQ (imem_req = 1), on imem_ack:
  - pend_valid = 0: inst <= imem_rdata, inst_pc <= pc, inst_valid <= 1, pc <= pc+4, go to VALID.
  - pend_valid = 1: discard data, pc <= pend_pc, clear pend_valid, stay in REQ and re-request next cycle.
- State REQ, redirect_valid without ack: pend_pc <= redirect_pc, pend_valid <= 1. A later redirect overwrites pend_pc. pc and imem_addr stay unchanged.
- State REQ, redirect_valid together with ack: discard data, pc <= redirect_pc, stay in REQ.
- State VALID (inst_valid = 1):
  - redirect_valid: inst_valid <= 0, pc <= redirect_pc, go to REQ. This holds even if stall is high; redirect beats stall.
  - else stall: hold inst, inst_pc, inst_valid and pc.
  - else: fetch_cnt <= fetch_cnt+1, inst_valid <= 0, go to REQ.
  - imem_req = 0 in VALID, so fetch issue rate is at most one instruction per 2 cycles.
- Arithmetic: pc+4 and fetch_cnt wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Latency: ack in cycle N gives inst_valid in cycle N+1.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0] != 0 is replaced by TRAP_VEC, including a pending redirect. misalign_err pulses high for 1 cycle in the cycle after the redirect is sampled.
- Undefined: redirect_pc[1:0] is forced to 00, and misalign_err is constant 0.

Decomposition:
- Package fetch_pkg:
  - state encoding BOOT = 2'd0, REQ = 2'd1, VALID = 2'd2;
  - INST_BYTES = 4;
  - default RESET_PC and TRAP_VEC constants.
- Sub-module fetch_boot_timer: BOOT_DELAY down-counter with a done output, reset asynchronously by rst.

Test Plan:
- Reset, BOOT_DELAY = 1, imem_ack returns 1 cycle after req -> first imem_req in cycle 2 after reset release with imem_addr 0x0; inst_valid with inst_pc 0x0, then the next request is to 0x4.
- stall held 3 cycles in VALID with inst 0x00500093 -> inst/inst_pc/inst_valid stable for 3 cycles; fetch_cnt increments only once stall drops.
- In VALID, redirect_valid with redirect_pc 0x40 and stall both high -> inst_valid drops next cycle, then imem_addr = 0x40.
- In REQ, ack delayed 3 cycles with redirect to 0x80 in the first wait cycle -> imem_addr stays at the old pc until ack, returned data produces no inst_valid, the next request is to 0x80.
- pc = 0xFFFF_FFFC fetch -> next imem_addr 0x0; fetch_cnt preloaded near 0xFFFF_FFFF wraps to 0.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> misalign_err 1-cycle pulse, next imem_addr = TRAP_VEC 0x10. Without the macro -> next address 0x100.
